// File: rtl/stopwatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl_if
//   Signal bundle between the stopwatch controller and its surroundings.
//   There is no valid/ready flow control on this bundle: tick_* are
//   single-cycle synchronous qualifiers, the buttons and switches are raw
//   asynchronous levels that the controller synchronises itself, and the
//   display outputs are plain registered levels that are always valid.
//
//   Modports
//     master : drives ticks/buttons/switches, observes display and state
//     slave  : the controller (stopwatch_ctrl)
//
//   Signals
//     tick_1hz, tick_2hz, tick_adj : one-cycle tick enables
//     btn_pause, btn_clear         : raw buttons (async)
//     sw_adj, sw_sel               : raw switches (async, level)
//     min_tens, min_ones           : BCD minutes
//     sec_tens, sec_ones           : BCD seconds
//     blank                        : per-digit blank, bit3 = min_tens, 1 = off
//     running                      : 1 while in RUN
//     state                        : FSM state (IDLE=0 RUN=1 PAUSE=2 ADJUST=3)
// ---------------------------------------------------------------------------
interface stopwatch_ctrl_if;
   logic       tick_1hz;
   logic       tick_2hz;
   logic       tick_adj;
   logic       btn_pause;
   logic       btn_clear;
   logic       sw_adj;
   logic       sw_sel;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic [3:0] blank;
   logic       running;
   logic [1:0] state;

   modport master (
      output tick_1hz, tick_2hz, tick_adj, btn_pause, btn_clear, sw_adj, sw_sel,
      input  min_tens, min_ones, sec_tens, sec_ones, blank, running, state
   );

   modport slave (
      input  tick_1hz, tick_2hz, tick_adj, btn_pause, btn_clear, sw_adj, sw_sel,
      output min_tens, min_ones, sec_tens, sec_ones, blank, running, state
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//   Run/pause/adjust controller for a MM:SS stopwatch. Synchronises the raw
//   buttons and switches, edge-detects the buttons, sequences a BCD time
//   register from the 1 Hz tick, lets the user step minutes or seconds from
//   the adjust tick, and produces digit values plus a blink blank mask.
//
//   Parameters
//     SYNC_STAGES : synchroniser flops per async input (>= 2)
//     MAX_MIN     : highest minute value before wrapping to 00 (<= 99)
//
//   Ports
//     clk  : system clock
//     rst  : asynchronous, active-low reset
//     bus  : stopwatch_ctrl_if.slave (ticks, buttons, switches in;
//            digits, blank, running, state out)
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_MIN     = 59
) (
   input  logic            clk,
   input  logic            rst,
   stopwatch_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSE  = 2'd2,
      ST_ADJUST = 2'd3
   } state_t;

   localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
   localparam logic [7:0] MAX_SEC_BCD = 8'h59;

   logic [SYNC_STAGES-1:0] pause_sync;
   logic [SYNC_STAGES-1:0] clear_sync;
   logic [SYNC_STAGES-1:0] adj_sync;
   logic [SYNC_STAGES-1:0] sel_sync;
   logic                   pause_last;
   logic                   clear_last;

   logic                   pause_edge;
   logic                   clear_edge;
   logic                   adj_on;
   logic                   sel_sec;

   state_t                 state_q, state_d;
   logic [7:0]             min_q, min_d;
   logic [7:0]             sec_q, sec_d;
   logic                   phase_q, phase_d;

   logic [7:0]             sec_step;
   logic [7:0]             min_step;
   logic [7:0]             min_carry;

   // Two-digit BCD increment with wrap to 00 after 'top'.
   function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] top);
      if (v == top)
         bcd_step = 8'h00;
      else if (v[3:0] == 4'd9)
         bcd_step = {v[7:4] + 4'd1, 4'd0};
      else
         bcd_step = {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Synchronisers plus one extra flop per button for rising-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pause_sync <= '0;
         clear_sync <= '0;
         adj_sync   <= '0;
         sel_sync   <= '0;
         pause_last <= 1'b0;
         clear_last <= 1'b0;
      end else begin
         pause_sync <= {pause_sync[SYNC_STAGES-2:0], bus.btn_pause};
         clear_sync <= {clear_sync[SYNC_STAGES-2:0], bus.btn_clear};
         adj_sync   <= {adj_sync[SYNC_STAGES-2:0], bus.sw_adj};
         sel_sync   <= {sel_sync[SYNC_STAGES-2:0], bus.sw_sel};
         pause_last <= pause_sync[SYNC_STAGES-1];
         clear_last <= clear_sync[SYNC_STAGES-1];
      end
   end

   assign pause_edge = pause_sync[SYNC_STAGES-1] & ~pause_last;
   assign clear_edge = clear_sync[SYNC_STAGES-1] & ~clear_last;
   assign adj_on     = adj_sync[SYNC_STAGES-1];
   assign sel_sec    = sel_sync[SYNC_STAGES-1];

   assign sec_step  = bcd_step(sec_q, MAX_SEC_BCD);
   assign min_step  = bcd_step(min_q, MAX_MIN_BCD);
   // Minutes only advance on a run tick when seconds roll over from 59.
   assign min_carry = (sec_q == MAX_SEC_BCD) ? min_step : min_q;

   // State and time registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         min_q   <= 8'h00;
         sec_q   <= 8'h00;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         phase_q <= phase_d;
      end
   end

   // Next-state and next-time logic. Priority: adjust switch, then clear
   // edge, then pause edge, then tick. Blink phase is held at 0 unless the
   // controller is already in ADJUST and the switch is still on, so it drops
   // to 0 on the same edge that leaves ADJUST.
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      phase_d = 1'b0;

      if (adj_on) begin
         state_d = ST_ADJUST;
         if (state_q == ST_ADJUST) begin
            phase_d = phase_q ^ bus.tick_2hz;
            if (clear_edge) begin
               min_d = 8'h00;
               sec_d = 8'h00;
            end else if (bus.tick_adj) begin
               // Fields step independently: no carry between them.
               if (sel_sec)
                  sec_d = sec_step;
               else
                  min_d = min_step;
            end
         end
      end else if (state_q == ST_ADJUST) begin
         state_d = ST_PAUSE;
      end else if (clear_edge) begin
         state_d = ST_IDLE;
         min_d   = 8'h00;
         sec_d   = 8'h00;
      end else begin
         // A tick coinciding with a pause edge in RUN is still counted.
         if ((state_q == ST_RUN) && bus.tick_1hz) begin
            sec_d = sec_step;
            min_d = min_carry;
         end
         if (pause_edge) begin
            case (state_q)
               ST_IDLE:  state_d = ST_RUN;
               ST_RUN:   state_d = ST_PAUSE;
               ST_PAUSE: state_d = ST_RUN;
               default:  state_d = state_q;
            endcase
         end
      end
   end

   assign bus.min_tens = min_q[7:4];
   assign bus.min_ones = min_q[3:0];
   assign bus.sec_tens = sec_q[7:4];
   assign bus.sec_ones = sec_q[3:0];
   assign bus.blank    = phase_q ? (sel_sec ? 4'b0011 : 4'b1100) : 4'b0000;
   assign bus.running  = (state_q == ST_RUN);
   assign bus.state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl. The reference model keeps the
//   time as plain integer minutes/seconds and the mode as a small integer,
//   updated at transaction level by the driver tasks.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   localparam int SYNC    = 2;
   localparam int MAX_MIN = 59;

   localparam int S_IDLE   = 0;
   localparam int S_RUN    = 1;
   localparam int S_PAUSE  = 2;
   localparam int S_ADJUST = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   stopwatch_ctrl_if bus ();

   stopwatch_ctrl #(
      .SYNC_STAGES (SYNC),
      .MAX_MIN     (MAX_MIN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   int m_min   = 0;
   int m_sec   = 0;
   int m_state = S_IDLE;
   int m_sel   = 0;
   int m_phase = 0;

   function automatic logic [15:0] exp_time();
      return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
   endfunction

   function automatic logic [15:0] obs_time();
      return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
   endfunction

   function automatic logic [3:0] exp_blank();
      if (m_phase == 0) return 4'b0000;
      return (m_sel != 0) ? 4'b0011 : 4'b1100;
   endfunction

   task automatic model_reset();
      m_min = 0; m_sec = 0; m_state = S_IDLE; m_phase = 0;
   endtask

   task automatic model_run_tick();
      int t;
      t = m_min * 60 + m_sec + 1;
      if (t >= (MAX_MIN + 1) * 60) t = 0;
      m_min = t / 60;
      m_sec = t % 60;
   endtask

   task automatic model_adj_step();
      if (m_sel != 0) m_sec = (m_sec + 1) % 60;
      else            m_min = (m_min + 1) % (MAX_MIN + 1);
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus.tick_1hz = 1'b0; bus.tick_2hz = 1'b0; bus.tick_adj = 1'b0;
      bus.btn_pause = 1'b0; bus.btn_clear = 1'b0;
      bus.sw_adj = 1'b0; bus.sw_sel = 1'b0;
   endtask

   task automatic pulse_1hz();
      bus.tick_1hz = 1'b1;
      @(negedge clk);
      bus.tick_1hz = 1'b0;
      if (m_state == S_RUN) model_run_tick();
   endtask

   task automatic pulse_adj(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick_adj = 1'b1;
         @(negedge clk);
         bus.tick_adj = 1'b0;
         if (m_state == S_ADJUST) model_adj_step();
      end
   endtask

   task automatic pulse_2hz();
      bus.tick_2hz = 1'b1;
      @(negedge clk);
      bus.tick_2hz = 1'b0;
      if (m_state == S_ADJUST) m_phase ^= 1;
   endtask

   // Press pause and/or clear; optionally land a 1 Hz tick on the very
   // cycle the press takes effect. Button is held a few cycles, released,
   // and the synchroniser is allowed to drain.
   task automatic press(input bit do_pause, input bit do_clear, input bit with_tick);
      bus.btn_pause = do_pause;
      bus.btn_clear = do_clear;
      repeat (SYNC) @(negedge clk);
      bus.tick_1hz = with_tick;
      @(negedge clk);
      bus.tick_1hz = 1'b0;
      if (m_state == S_ADJUST) begin
         if (do_clear) begin m_min = 0; m_sec = 0; end
      end else if (do_clear) begin
         m_min = 0; m_sec = 0; m_state = S_IDLE;
      end else begin
         if (with_tick && m_state == S_RUN) model_run_tick();
         if (do_pause) m_state = (m_state == S_RUN) ? S_PAUSE : S_RUN;
      end
      repeat (3) @(negedge clk);
      bus.btn_pause = 1'b0;
      bus.btn_clear = 1'b0;
      repeat (SYNC + 2) @(negedge clk);
   endtask

   task automatic set_adj(input bit v);
      bus.sw_adj = v;
      repeat (SYNC + 1) @(negedge clk);
      if (v) begin
         if (m_state != S_ADJUST) m_phase = 0;
         m_state = S_ADJUST;
      end else if (m_state == S_ADJUST) begin
         m_state = S_PAUSE;
         m_phase = 0;
      end
   endtask

   task automatic set_sel(input bit v);
      bus.sw_sel = v;
      repeat (SYNC + 1) @(negedge clk);
      m_sel = v;
   endtask

   // Load a time through ADJUST, leave in PAUSE.
   task automatic load_time(input int mn, input int sc);
      set_adj(1'b1);
      press(1'b0, 1'b1, 1'b0);
      set_sel(1'b0);
      pulse_adj(mn);
      set_sel(1'b1);
      pulse_adj(sc);
      set_adj(1'b0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (obs_time() !== 16'h0000) begin errors++; $display("FAIL reset_time: got %h expected 0000", obs_time()); end
      checks++;
      if (bus.blank !== 4'b0000) begin errors++; $display("FAIL reset_blank: got %b expected 0000", bus.blank); end
      checks++;
      if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", bus.running); end
      checks++;
      if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      checks++;
      if (bus.state !== 2'd0) begin errors++; $display("FAIL post_reset_state: got %0d expected 0", bus.state); end
   endtask

   task automatic test_pause_presses();
      int prev_s, next_s, exp_s;
      for (int p = 0; p < 3; p++) begin
         prev_s = m_state;
         next_s = (prev_s == S_RUN) ? S_PAUSE : S_RUN;
         bus.btn_pause = 1'b1;
         for (int k = 1; k <= SYNC + 1; k++) begin
            @(negedge clk);
            exp_s = (k <= SYNC) ? prev_s : next_s;
            checks++;
            if (bus.state !== 2'(exp_s)) begin
               errors++;
               $display("FAIL press%0d_edge%0d_state: got %0d expected %0d", p, k, bus.state, exp_s);
            end
         end
         m_state = next_s;
         repeat (4) @(negedge clk);
         checks++;
         if (bus.state !== 2'(m_state)) begin errors++; $display("FAIL press%0d_held_state: got %0d expected %0d", p, bus.state, m_state); end
         bus.btn_pause = 1'b0;
         repeat (SYNC + 2) @(negedge clk);
         checks++;
         if (bus.running !== (m_state == S_RUN)) begin errors++; $display("FAIL press%0d_running: got %b expected %b", p, bus.running, m_state == S_RUN); end
      end
      checks++;
      if (obs_time() !== 16'h0000) begin errors++; $display("FAIL press_time: got %h expected 0000", obs_time()); end
   endtask

   task automatic test_run_carry();
      logic [15:0] want [3];
      want[0] = 16'h0059; want[1] = 16'h0100; want[2] = 16'h0101;
      // Currently RUN at 00:00; random gaps between ticks.
      while (m_sec < 58) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         pulse_1hz();
         checks++;
         if (obs_time() !== exp_time()) begin errors++; $display("FAIL run_count: got %h expected %h", obs_time(), exp_time()); end
      end
      for (int i = 0; i < 3; i++) begin
         pulse_1hz();
         checks++;
         if (obs_time() !== want[i]) begin errors++; $display("FAIL run_carry%0d: got %h expected %h", i, obs_time(), want[i]); end
      end
      load_time(59, 59);
      checks++;
      if (obs_time() !== 16'h5959) begin errors++; $display("FAIL preload_5959: got %h expected 5959", obs_time()); end
      checks++;
      if (bus.state !== 2'd2) begin errors++; $display("FAIL adj_exit_state: got %0d expected 2", bus.state); end
      press(1'b1, 1'b0, 1'b0);
      pulse_1hz();
      checks++;
      if (obs_time() !== 16'h0000) begin errors++; $display("FAIL wrap_5959: got %h expected 0000", obs_time()); end
      checks++;
      if (bus.state !== 2'd1) begin errors++; $display("FAIL wrap_state: got %0d expected 1", bus.state); end
   endtask

   task automatic test_tick_and_pause();
      repeat (10) pulse_1hz();
      checks++;
      if (obs_time() !== 16'h0010) begin errors++; $display("FAIL tp_pre: got %h expected 0010", obs_time()); end
      press(1'b1, 1'b0, 1'b1);
      checks++;
      if (obs_time() !== 16'h0011) begin errors++; $display("FAIL tp_time: got %h expected 0011", obs_time()); end
      checks++;
      if (bus.state !== 2'd2) begin errors++; $display("FAIL tp_state: got %0d expected 2", bus.state); end
      repeat (5) pulse_1hz();
      checks++;
      if (obs_time() !== 16'h0011) begin errors++; $display("FAIL tp_frozen: got %h expected 0011", obs_time()); end
   endtask

   task automatic test_clear_and_pause();
      load_time(12, 34);
      press(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_time() !== 16'h1234 || bus.state !== 2'd1) begin
         errors++; $display("FAIL cp_pre: got %h/%0d expected 1234/1", obs_time(), bus.state);
      end
      press(1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_time() !== 16'h0000) begin errors++; $display("FAIL cp_time: got %h expected 0000", obs_time()); end
      checks++;
      if (bus.state !== 2'd0) begin errors++; $display("FAIL cp_state: got %0d expected 0", bus.state); end
      checks++;
      if (bus.running !== 1'b0) begin errors++; $display("FAIL cp_running: got %b expected 0", bus.running); end
   endtask

   task automatic test_adjust();
      logic [15:0] want [3];
      want[0] = 16'h0559; want[1] = 16'h0500; want[2] = 16'h0501;
      load_time(5, 58);
      set_adj(1'b1);
      checks++;
      if (obs_time() !== 16'h0558 || bus.state !== 2'd3) begin
         errors++; $display("FAIL adj_pre: got %h/%0d expected 0558/3", obs_time(), bus.state);
      end
      for (int i = 0; i < 3; i++) begin
         pulse_adj(1);
         checks++;
         if (obs_time() !== want[i]) begin errors++; $display("FAIL adj_step%0d: got %h expected %h", i, obs_time(), want[i]); end
      end
      pulse_1hz();
      press(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_time() !== 16'h0501 || bus.state !== 2'd3) begin
         errors++; $display("FAIL adj_ignore: got %h/%0d expected 0501/3", obs_time(), bus.state);
      end
      checks++;
      if (bus.blank !== 4'b0000) begin errors++; $display("FAIL blink0: got %b expected 0000", bus.blank); end
      pulse_2hz();
      checks++;
      if (bus.blank !== 4'b0011) begin errors++; $display("FAIL blink1: got %b expected 0011", bus.blank); end
      pulse_2hz();
      checks++;
      if (bus.blank !== 4'b0000) begin errors++; $display("FAIL blink2: got %b expected 0000", bus.blank); end
      pulse_2hz();
      checks++;
      if (bus.blank !== 4'b0011) begin errors++; $display("FAIL blink3: got %b expected 0011", bus.blank); end
      set_sel(1'b0);
      checks++;
      if (bus.blank !== 4'b1100) begin errors++; $display("FAIL blink_sel: got %b expected 1100", bus.blank); end
      set_adj(1'b0);
      checks++;
      if (bus.state !== 2'd2 || bus.blank !== 4'b0000 || obs_time() !== 16'h0501) begin
         errors++; $display("FAIL adj_exit: got %0d/%b/%h expected 2/0000/0501", bus.state, bus.blank, obs_time());
      end
   endtask

   task automatic test_random();
      press(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         bus.tick_1hz = ($urandom_range(0, 2) == 0);
         bus.tick_2hz = ($urandom_range(0, 3) == 0);
         bus.tick_adj = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         if (bus.tick_1hz) model_run_tick();
         idle_ticks();
         checks++;
         if (obs_time() !== exp_time() || bus.blank !== 4'b0000) begin
            errors++; $display("FAIL rand_run%0d: got %h/%b expected %h/0000", i, obs_time(), bus.blank, exp_time());
         end
      end
      set_adj(1'b1);
      for (int seg = 0; seg < 2; seg++) begin
         set_sel(seg[0]);
         for (int i = 0; i < 150; i++) begin
            bus.tick_1hz = ($urandom_range(0, 2) == 0);
            bus.tick_2hz = ($urandom_range(0, 3) == 0);
            bus.tick_adj = ($urandom_range(0, 1) == 0);
            @(negedge clk);
            if (bus.tick_adj) model_adj_step();
            if (bus.tick_2hz) m_phase ^= 1;
            idle_ticks();
            checks++;
            if (obs_time() !== exp_time() || bus.blank !== exp_blank()) begin
               errors++;
               $display("FAIL rand_adj%0d_%0d: got %h/%b expected %h/%b", seg, i, obs_time(), bus.blank, exp_time(), exp_blank());
            end
         end
      end
      set_adj(1'b0);
      checks++;
      if (bus.state !== 2'(m_state) || obs_time() !== exp_time()) begin
         errors++; $display("FAIL rand_exit: got %0d/%h expected %0d/%h", bus.state, obs_time(), m_state, exp_time());
      end
   endtask

   task automatic idle_ticks();
      bus.tick_1hz = 1'b0;
      bus.tick_2hz = 1'b0;
      bus.tick_adj = 1'b0;
   endtask

   task automatic test_async_reset();
      load_time(7, 7);
      press(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_time() !== 16'h0707 || bus.state !== 2'd1) begin
         errors++; $display("FAIL ar_pre: got %h/%0d expected 0707/1", obs_time(), bus.state);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      model_reset();
      checks++;
      if (obs_time() !== 16'h0000) begin errors++; $display("FAIL ar_time: got %h expected 0000", obs_time()); end
      checks++;
      if (bus.state !== 2'd0 || bus.running !== 1'b0 || bus.blank !== 4'b0000) begin
         errors++; $display("FAIL ar_ctrl: got %0d/%b/%b expected 0/0/0000", bus.state, bus.running, bus.blank);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      press(1'b1, 1'b0, 1'b0);
      pulse_1hz();
      checks++;
      if (obs_time() !== 16'h0001 || bus.state !== 2'd1) begin
         errors++; $display("FAIL ar_restart: got %h/%0d expected 0001/1", obs_time(), bus.state);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle_inputs();
      test_reset();
      test_pause_presses();
      test_run_carry();
      test_tick_and_pause();
      test_clear_and_pause();
      test_adjust();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run/pause/adjust controller for the stopwatch. It consumes single-cycle tick enables from the clock-divider wrapper (1 Hz count, 2 Hz blink, 5 Hz adjust-step) and the raw pause/clear buttons and adjust/select switches. It sequences a BCD MM:SS time register and produces the digit values and blank mask for the 7-segment multiplexer.

Parameters:
SYNC_STAGES, 2, synchroniser flops per async input (button/switch), min 2
MAX_MIN, 59, highest minute value before wrap to 00 (BCD-representable, ≤99)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-low reset
tick_1hz  in  1  one-cycle pulse, advance time by 1 s in RUN
tick_2hz  in  1  one-cycle pulse, toggle blink phase in ADJUST
tick_adj  in  1  one-cycle pulse, step selected field in ADJUST
btn_pause  in  1  raw pause/start button (debounced externally, async to clk)
btn_clear  in  1  raw clear button (async)
sw_adj  in  1  adjust-mode switch (async, level)
sw_sel  in  1  adjust field select: 0 = minutes, 1 = seconds (async, level)
min_tens  out  4  BCD minutes tens
min_ones  out  4  BCD minutes ones
sec_tens  out  4  BCD seconds tens (0..5)
sec_ones  out  4  BCD seconds ones
blank  out  4  per-digit blank, bit3=min_tens .. bit0=sec_ones, 1 = off
running  out  1  1 while state = RUN
state  out  2  IDLE=0, RUN=1, PAUSE=2, ADJUST=3

Behaviour:
- Reset (rst=0, async): all digits 0, blank=0, running=0, state=IDLE, blink phase 0, synchroniser/edge flops 0. Release is synchronous to clk.
- All async inputs pass through SYNC_STAGES flops; buttons get a rising-edge detector (one extra flop). Press acted on at the clk edge SYNC_STAGES+1 edges after first sampled high; held button = one event.
- Ticks are synchronous; a tick affects registers at the same edge it is sampled; outputs reflect it next cycle.
- State priority per cycle: synced sw_adj > clear edge > pause edge > tick.
- IDLE: time 00:00. Pause edge -> RUN.
- RUN: tick_1hz increments time; sec_ones 9->0 carries to sec_tens; 59 s -> 00 carries to minutes; MAX_MIN:59 -> 00:00. Pause edge -> PAUSE. Tick and pause edge same cycle: increment applied, then PAUSE.
- PAUSE: time frozen. Pause edge -> RUN.
- Clear edge in IDLE/RUN/PAUSE: time <- 00:00, state <- IDLE; clear beats pause in same cycle; a coincident tick is discarded.
- sw_adj=1 (synced) from any state -> ADJUST; counting halts. In ADJUST: tick_adj increments selected field by 1 (seconds 59->00, minutes MAX_MIN->00), no carry between fields; tick_1hz ignored; pause edges ignored; clear edge zeros time, stays ADJUST.
- Blink phase toggles on tick_2hz only in ADJUST; forced 0 outside ADJUST. blank = phase ? (sw_sel ? 4'b0011 : 4'b1100) : 4'b0000. sw_sel change mid-ADJUST takes effect after sync, no reset of phase.
- sw_adj falling (synced) -> PAUSE with adjusted time retained.
- Digits always valid BCD; no illegal codes reachable. Unused state encodings are never reached.

Test Plan:
- Reset then 3 pause presses with ticks idle -> state IDLE->RUN->PAUSE->RUN, each change exactly SYNC_STAGES+1 edges after press; time stays 00:00.
- RUN from 00:58, three tick_1hz -> 00:59, 01:00, 01:01; preload 59:59 + one tick -> 00:00.
- RUN, tick_1hz and pause edge same cycle at 00:10 -> 00:11, state PAUSE; further ticks hold 00:11.
- RUN at 12:34, clear and pause edges same cycle -> 00:00, IDLE, running=0.
- sw_adj=1, sw_sel=1 at 05:58, three tick_adj -> 05:59, 05:00, 05:01 (no minute carry); tick_2hz toggles blank 0000<->0011; sw_sel=0 -> 1100 pattern; sw_adj=0 -> PAUSE, blank=0000.
- rst asserted mid-RUN at 07:07, between clk edges -> outputs zero and IDLE immediately without clk edge; after release, pause press starts from 00:00.
